bc_scheduler: RTL and testbench

- Shares one control/datapath pair (control block with START/RST/finished handshake, datapath exposing X input and S result) between two requesters.
- Round-robin arbitration; per job: clear controller, launch it, wait for completion, capture result, acknowledge requester.
- Sits between requester blocks and the existing control block; the control block itself is untouched.

---
 rtl/bc_sched_pkg.sv | 17 +
 rtl/bc_scheduler_if.sv | 32 +++
 rtl/bc_rr_arb2.sv | 15 +
 rtl/bc_scheduler.sv | 142 ++++++++++++++
 tb/tb_bc_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bc_sched_pkg.sv
// Shared constants for the two-requester control-block scheduler:
// state encoding and default operand/watchdog sizing.
package bc_sched_pkg;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned TIMEOUT_DEF = 32;
  localparam int unsigned CW_DEF      = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bc_scheduler_if.sv
// Requester-side and control-block-side signals of bc_scheduler.
// master = scheduler view, slave = surrounding environment view.
interface bc_scheduler_if
  import bc_sched_pkg::*;
#(
  parameter int unsigned W = W_DEF
);

  logic [1:0]   req;
  logic [W-1:0] x0;
  logic [W-1:0] x1;
  logic [1:0]   ack;
  logic [W-1:0] result;
  logic         err;
  logic         busy;
  logic         dp_rst;
  logic         dp_start;
  logic [W-1:0] dp_x;
  logic         dp_finished;
  logic [W-1:0] dp_result;

  modport master (
    input  req, x0, x1, dp_finished, dp_result,
    output ack, result, err, busy, dp_rst, dp_start, dp_x
  );

  modport slave (
    output req, x0, x1, dp_finished, dp_result,
    input  ack, result, err, busy, dp_rst, dp_start, dp_x
  );

endinterface

// File: rtl/bc_rr_arb2.sv
// Combinational two-way round-robin pick; the pointer names the favoured
// requester when both ask, and always moves to the one not granted.
module bc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       gid_c,
  output logic       valid_c,
  output logic       ptr_nxt_c
);

  assign valid_c   = |req;
  assign gid_c     = (req == 2'b11) ? rr_ptr : req[1];
  assign ptr_nxt_c = ~gid_c;

endmodule

// File: rtl/bc_scheduler.sv
// Shares one control block + datapath between two requesters: clear, launch,
// wait for finished, capture S, ack. Optional watchdog: BC_SCHED_WATCHDOG_EN.
module bc_scheduler
  import bc_sched_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input logic            clk,
  input logic            RST,
  bc_scheduler_if.master bus
);

  if ((64'd1 << CW) <= 64'(TIMEOUT)) begin : g_cw_check
    $error("bc_scheduler: CW too narrow to count to TIMEOUT");
  end

  state_t       state, state_nxt;
  logic         rr_ptr, rr_ptr_nxt;
  logic         gid, gid_nxt;
  logic [W-1:0] x_q, x_nxt;
  logic [W-1:0] result_q, result_nxt;
  logic [1:0]   ack_q, ack_nxt;
  logic         err_q, err_nxt;
  logic         busy_q, busy_nxt;
  logic         dp_rst_q, dp_rst_nxt;
  logic         dp_start_q, dp_start_nxt;
  logic         arb_gid_c, arb_valid_c, arb_ptr_c;
`ifdef BC_SCHED_WATCHDOG_EN
  logic [CW-1:0] wd_cnt, wd_nxt;
`endif

  bc_rr_arb2 u_arb (
    .req      (bus.req),
    .rr_ptr   (rr_ptr),
    .gid_c    (arb_gid_c),
    .valid_c  (arb_valid_c),
    .ptr_nxt_c(arb_ptr_c)
  );

  // Next state; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_nxt  = S_IDLE;
    rr_ptr_nxt = rr_ptr;
    gid_nxt    = gid;
    x_nxt      = x_q;
    result_nxt = result_q;
    ack_nxt    = 2'b00;
    err_nxt    = 1'b0;
`ifdef BC_SCHED_WATCHDOG_EN
    wd_nxt     = wd_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (arb_valid_c) begin
          gid_nxt    = arb_gid_c;
          rr_ptr_nxt = arb_ptr_c;
          x_nxt      = arb_gid_c ? bus.x1 : bus.x0;
          state_nxt  = S_CLEAR;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_CLEAR:  state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        state_nxt = S_WAIT;
`ifdef BC_SCHED_WATCHDOG_EN
        wd_nxt    = '0;
`endif
      end
      S_WAIT: begin
        if (bus.dp_finished) begin
          state_nxt  = S_DONE;
          result_nxt = bus.dp_result;
          ack_nxt    = gid ? 2'b10 : 2'b01;
        end
`ifdef BC_SCHED_WATCHDOG_EN
        else if (wd_cnt == CW'(TIMEOUT - 1)) begin
          state_nxt  = S_DONE;
          result_nxt = '0;
          ack_nxt    = gid ? 2'b10 : 2'b01;
          err_nxt    = 1'b1;
        end else begin
          state_nxt  = S_WAIT;
          wd_nxt     = wd_cnt + CW'(1);
        end
`else
        else begin
          state_nxt  = S_WAIT;
        end
`endif
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt     = (state_nxt != S_IDLE);
    dp_rst_nxt   = (state_nxt == S_CLEAR) || (state_nxt == S_DONE);
    dp_start_nxt = (state_nxt == S_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      gid        <= 1'b0;
      x_q        <= '0;
      result_q   <= '0;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      dp_rst_q   <= 1'b1;
      dp_start_q <= 1'b0;
`ifdef BC_SCHED_WATCHDOG_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gid        <= gid_nxt;
      x_q        <= x_nxt;
      result_q   <= result_nxt;
      ack_q      <= ack_nxt;
      err_q      <= err_nxt;
      busy_q     <= busy_nxt;
      dp_rst_q   <= dp_rst_nxt;
      dp_start_q <= dp_start_nxt;
`ifdef BC_SCHED_WATCHDOG_EN
      wd_cnt     <= wd_nxt;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.dp_rst   = dp_rst_q;
  assign bus.dp_start = dp_start_q;
  assign bus.dp_x     = x_q;

endmodule

// File: tb/tb_bc_scheduler.sv
// Bench for bc_scheduler: a control-block model, a job-timeline reference model
// compared every cycle, and directed jobs with hand-computed expectations.
module tb_bc_scheduler;

  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 32;

  logic clk = 1'b0;
  logic RST = 1'b1;

  bc_scheduler_if #(.W(W)) bus ();

  bc_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .CW(6)) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Control block model: finished rises after tdp WAIT cycles (tdp=0: never),
  // S = 8*X + 2, finished held until dp_rst.
  int   tdp     = 6;
  bit   dpm_act = 1'b0;
  int   dpm_cnt = 0;
  logic dpm_fin = 1'b0;
  logic stray   = 1'b0;

  assign bus.dp_finished = dpm_fin | stray;

  always @(posedge clk) begin
    if (bus.dp_rst) begin
      dpm_act <= 1'b0;
      dpm_fin <= 1'b0;
      dpm_cnt <= 0;
    end else if (bus.dp_start) begin
      dpm_act       <= 1'b1;
      dpm_cnt       <= 0;
      dpm_fin       <= (tdp == 1);
      bus.dp_result <= 8'(bus.dp_x * 8 + 2);
    end else if (dpm_act && !dpm_fin && tdp > 1) begin
      dpm_cnt <= dpm_cnt + 1;
      if (dpm_cnt + 1 == tdp - 1) dpm_fin <= 1'b1;
    end
  end

  // Reference model: a job is a timeline measured in cycles since grant
  // (1 = clear, 2 = launch, 3.. = waiting), closed by one done cycle.
  bit         armed = 1'b0;
  bit         m_busy, m_done, m_ptr, m_gid;
  int         m_age;
  logic [7:0] m_x, m_res;
  logic [1:0] e_ack;
  logic       e_err, e_rst, e_start;

  always @(posedge clk) begin
    logic [1:0] r;
    logic       f;
    r = bus.req;
    f = bus.dp_finished;
    if (RST) begin
      armed = 1'b1; m_busy = 0; m_done = 0; m_ptr = 0; m_gid = 0;
      m_age = 0; m_x = '0; m_res = '0; e_ack = 2'b00; e_err = 1'b0;
    end else if (armed) begin
      e_ack = 2'b00;
      e_err = 1'b0;
      if (m_done) begin
        m_busy = 0;
        m_done = 0;
      end else if (m_busy) begin
        if (m_age >= 3 && f) begin
          m_done = 1; m_res = bus.dp_result;
          e_ack  = m_gid ? 2'b10 : 2'b01;
        end
`ifdef BC_SCHED_WATCHDOG_EN
        else if (m_age >= 3 && m_age - 2 == TIMEOUT) begin
          m_done = 1; m_res = '0; e_err = 1'b1;
          e_ack  = m_gid ? 2'b10 : 2'b01;
        end
`endif
        else m_age++;
      end else if (r != 2'b00) begin
        m_gid  = (r == 2'b11) ? m_ptr : r[1];
        m_ptr  = !m_gid;
        m_x    = m_gid ? bus.x1 : bus.x0;
        m_busy = 1;
        m_age  = 1;
      end
    end
    e_rst   = RST || (m_busy && (m_age == 1 || m_done));
    e_start = m_busy && !m_done && m_age == 2;
    #1;
    if (armed) begin
      check("busy",     32'(bus.busy),     32'(m_busy));
      check("dp_rst",   32'(bus.dp_rst),   32'(e_rst));
      check("dp_start", 32'(bus.dp_start), 32'(e_start));
      check("dp_x",     32'(bus.dp_x),     32'(m_x));
      check("ack",      32'(bus.ack),      32'(e_ack));
      check("err",      32'(bus.err),      32'(e_err));
      check("result",   32'(bus.result),   32'(m_res));
    end
  end

  // Cycle 1 is the cycle in which req is presented; returns the cycle holding ack.
  task automatic wait_ack(input int maxc, output int cyc, output logic [1:0] a,
                          output logic [7:0] res, output logic e);
    cyc = 1; a = 2'b00; res = '0; e = 1'b0;
    repeat (maxc) begin
      @(posedge clk); #2;
      cyc++;
      if (bus.ack != 2'b00) begin
        a = bus.ack; res = bus.result; e = bus.err;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_wait: no ack within %0d cycles, required one", maxc);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); RST = 1'b1;
    repeat (n) @(negedge clk);
    RST = 1'b0;
  endtask

  int         cyc;
  logic [1:0] a;
  logic [7:0] res;
  logic       e;

  initial begin
    bus.req = 2'b00; bus.x0 = '0; bus.x1 = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy",   32'(bus.busy),   32'(0));
    check("rst_dp_rst", 32'(bus.dp_rst), 32'(1));
    check("rst_ack",    32'(bus.ack),    32'(0));
    @(negedge clk); RST = 1'b0;
    repeat (2) @(negedge clk);

    // Single job; x0 toggles mid-WAIT and must not reach dp_x.
    bus.x0 = 8'h05; bus.req = 2'b01;
    fork
      begin repeat (5) @(negedge clk); bus.x0 = 8'h77; end
    join_none
    wait_ack(30, cyc, a, res, e);
    check("single_latency", 32'(cyc), 32'(10));
    check("single_ack",     32'(a),   32'(2'b01));
    check("single_result",  32'(res), 32'(8'h2A));
    check("single_err",     32'(e),   32'(0));
    check("single_dp_x",    32'(bus.dp_x), 32'(8'h05));
    @(negedge clk); bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset(2);
    bus.x0 = 8'h01; bus.x1 = 8'h02; bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_ack(40, cyc, a, res, e);
      check("contend_ack",    32'(a),   (j % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      check("contend_result", 32'(res), (j % 2 == 0) ? 32'(8'h0A) : 32'(8'h12));
    end
    @(negedge clk); bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Stray finished while idle.
    stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("stray_busy", 32'(bus.busy), 32'(0));
    check("stray_ack",  32'(bus.ack),  32'(0));

    // Reset during WAIT abandons the job, then a fresh request is served.
    @(negedge clk); bus.x1 = 8'h03; bus.req = 2'b10;
    repeat (5) @(negedge clk);
    RST = 1'b1; bus.req = 2'b00;
    @(posedge clk); #2;
    check("midrst_busy",   32'(bus.busy),   32'(0));
    check("midrst_dp_rst", 32'(bus.dp_rst), 32'(1));
    check("midrst_ack",    32'(bus.ack),    32'(0));
    @(negedge clk); RST = 1'b0;
    @(negedge clk); bus.req = 2'b10;
    wait_ack(30, cyc, a, res, e);
    check("after_rst_latency", 32'(cyc), 32'(10));
    check("after_rst_ack",     32'(a),   32'(2'b10));
    check("after_rst_result",  32'(res), 32'(8'h1A));
    @(negedge clk); bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Control block never finishes.
    tdp = 0;
    bus.x0 = 8'h09; bus.req = 2'b01;
`ifdef BC_SCHED_WATCHDOG_EN
    wait_ack(60, cyc, a, res, e);
    check("wd_latency", 32'(cyc), 32'(TIMEOUT + 4));
    check("wd_ack",     32'(a),   32'(2'b01));
    check("wd_err",     32'(e),   32'(1));
    check("wd_result",  32'(res), 32'(0));
    @(negedge clk); bus.req = 2'b00;
`else
    repeat (45) @(posedge clk);
    #2;
    check("hang_busy", 32'(bus.busy), 32'(1));
    check("hang_err",  32'(bus.err),  32'(0));
    check("hang_ack",  32'(bus.ack),  32'(0));
    @(negedge clk); bus.req = 2'b00;
    do_reset(1);
`endif
    tdp = 6;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
